// File: rtl/mem_responder.sv
// Word memory responder: one read/write per request, mem_ready LATENCY cycles after the request edge.
// Initiator holds the request until mem_ready is seen; MEM_ACCESS_CNT_EN adds rd_count/wr_count outputs.
module mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 mem_ready,
  output logic                 bus_err
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [WORD_SIZE-1:0] rd_count,
  output logic [WORD_SIZE-1:0] wr_count
`endif
);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("mem_responder: LATENCY must be >= 1");
    end
  endgenerate

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t                state;
  logic [ADDR_BITS-1:0]  addr_q;
  logic                  is_rd_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic [CW-1:0]         cnt;
  logic [WORD_SIZE-1:0]  mem [2**ADDR_BITS];

  logic active;
  logic commit;
  logic unused_addr_hi;

  // Upper address bits alias onto the implemented depth.
  assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];

  assign active = is_rd_q ? readM : writeM;
  assign commit = (state == BUSY) && active && (cnt == '0);

  // Drive enable follows readM directly so the bus frees in the cycle readM falls.
  assign data = ((state == DONE) && is_rd_q && readM) ? rdata_q : 'z;

  always_ff @(posedge clk) begin
    if (commit && !is_rd_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      is_rd_q   <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (readM && writeM) begin
            state   <= ERR;
            bus_err <= 1'b1;
          end else if (readM || writeM) begin
            addr_q  <= address[ADDR_BITS-1:0];
            is_rd_q <= readM;
            if (writeM) begin
              wdata_q <= data;
            end
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!active) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state     <= DONE;
            mem_ready <= 1'b1;
            if (is_rd_q) begin
              rdata_q <= mem[addr_q];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!active) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
          end
        end
        ERR: begin
          if (!readM && !writeM) begin
            state   <= IDLE;
            bus_err <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  // Only accesses that reach DONE are counted; aborts and protocol errors never commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (commit) begin
      if (is_rd_q) begin
        rd_count <= rd_count + 1'b1;
      end else begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end
`else
  // Access counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=2 and LATENCY=1 instances checked against a word-array model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_r   [2];
  logic        wr_r   [2];
  logic [15:0] addr_r [2];
  logic        tb_en  [2];
  logic [15:0] tb_dat [2];

  wire  [15:0] bus0, bus1;
  wire         rdy0, rdy1, err0, err1;
`ifdef MEM_ACCESS_CNT_EN
  wire  [15:0] rc0, wc0, rc1, wc1;
`endif

  logic [15:0] mem_m [2][256];
  int          lat   [2] = '{2, 1};
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign bus0 = tb_en[0] ? tb_dat[0] : 'z;
  assign bus1 = tb_en[1] ? tb_dat[1] : 'z;

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .readM(rd_r[0]), .writeM(wr_r[0]),
    .address(addr_r[0]), .data(bus0), .mem_ready(rdy0), .bus_err(err0)
`ifdef MEM_ACCESS_CNT_EN
    , .rd_count(rc0), .wr_count(wc0)
`endif
  );

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .readM(rd_r[1]), .writeM(wr_r[1]),
    .address(addr_r[1]), .data(bus1), .mem_ready(rdy1), .bus_err(err1)
`ifdef MEM_ACCESS_CNT_EN
    , .rd_count(rc1), .wr_count(wc1)
`endif
  );

  function automatic logic [15:0] bus_of(input int s);
    return (s == 0) ? bus0 : bus1;
  endfunction

  function automatic logic rdy_of(input int s);
    return (s == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic err_of(input int s);
    return (s == 0) ? err0 : err1;
  endfunction

  // Briefly drives pattern p onto the bus and returns what the bus resolves to.
  task automatic sense(input int s, input logic [15:0] p, output logic [15:0] o);
    logic        sv_en;
    logic [15:0] sv_dat;
    sv_en     = tb_en[s];
    sv_dat    = tb_dat[s];
    tb_en[s]  = 1'b1;
    tb_dat[s] = p;
    #1;
    o         = bus_of(s);
    tb_en[s]  = sv_en;
    tb_dat[s] = sv_dat;
  endtask

  task automatic do_access(input int s, input bit is_rd, input logic [15:0] a,
                           input logic [15:0] wd, input string nm);
    int          L;
    logic [15:0] exp_d, p, o0, o1;
    L     = lat[s];
    exp_d = mem_m[s][a % 256];
    @(posedge clk); #1;
    addr_r[s] = a;
    if (is_rd) rd_r[s] = 1'b1;
    else begin
      wr_r[s]   = 1'b1;
      tb_en[s]  = 1'b1;
      tb_dat[s] = wd;
    end
    @(posedge clk);
    for (int c = 0; c <= L; c++) begin
      if (c > 0) @(posedge clk);
      if (c < L) begin
        #1;
        addr_r[s] = 16'($urandom);
        if (!is_rd) tb_dat[s] = 16'($urandom);
      end
      @(negedge clk);
      n_cmp++;
      if (rdy_of(s) !== 1'(c >= L)) begin
        n_bad++;
        $display("FAIL %s ready at edge+%0d: saw %b required %b", nm, c, rdy_of(s), c >= L);
      end
    end
    if (is_rd) begin
      n_cmp++;
      if (bus_of(s) !== exp_d) begin
        n_bad++;
        $display("FAIL %s read data addr %h: saw %h required %h", nm, a, bus_of(s), exp_d);
      end
    end else begin
      p = 16'($urandom);
      sense(s, p, o0);
      sense(s, ~p, o1);
      n_cmp++;
      if (o0 !== p || o1 !== ~p) begin
        n_bad++;
        $display("FAIL %s bus driven during write: saw %h/%h required %h/%h", nm, o0, o1, p, ~p);
      end
      mem_m[s][a % 256] = wd;
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (rdy_of(s) !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready hold: saw %b required 1", nm, rdy_of(s));
    end
    #1;
    rd_r[s]  = 1'b0;
    wr_r[s]  = 1'b0;
    tb_en[s] = 1'b0;
    p = 16'($urandom);
    sense(s, p, o0);
    sense(s, ~p, o1);
    n_cmp++;
    if (o0 !== p || o1 !== ~p || rdy_of(s) !== 1'b1) begin
      n_bad++;
      $display("FAIL %s release on drop: bus %h/%h required %h/%h, ready %b required 1",
               nm, o0, o1, p, ~p, rdy_of(s));
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (rdy_of(s) !== 1'b0 || err_of(s) !== 1'b0) begin
      n_bad++;
      $display("FAIL %s back to idle: ready %b err %b required 0 0", nm, rdy_of(s), err_of(s));
    end
  endtask

  task automatic test_reset();
    logic [15:0] p, o0, o1;
    for (int s = 0; s < 2; s++) begin
      p = 16'($urandom);
      sense(s, p, o0);
      sense(s, ~p, o1);
      n_cmp++;
      if (rdy_of(s) !== 1'b0 || err_of(s) !== 1'b0 || o0 !== p || o1 !== ~p) begin
        n_bad++;
        $display("FAIL reset state dut%0d: ready %b err %b bus %h/%h required 0 0 %h/%h",
                 s, rdy_of(s), err_of(s), o0, o1, p, ~p);
      end
    end
  endtask

  task automatic test_basic();
    do_access(0, 1'b0, 16'h0010, 16'hBEEF, "basic_wr");
    do_access(0, 1'b1, 16'h0010, 16'h0000, "basic_rd");
  endtask

  task automatic abort_write(input int s, input logic [15:0] a, input logic [15:0] wd);
    int L;
    L = lat[s];
    @(posedge clk); #1;
    addr_r[s] = a; wr_r[s] = 1'b1; tb_en[s] = 1'b1; tb_dat[s] = wd;
    @(posedge clk);
    for (int c = 0; c < L + 3; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if (c == L - 1) begin
        #1;
        wr_r[s]  = 1'b0;
        tb_en[s] = 1'b0;
      end
      n_cmp++;
      if (rdy_of(s) !== 1'b0) begin
        n_bad++;
        $display("FAIL abort dut%0d ready at edge+%0d: saw %b required 0", s, c, rdy_of(s));
      end
    end
  endtask

  task automatic test_abort();
    abort_write(0, 16'h0020, 16'h1234);
    do_access(0, 1'b1, 16'h0020, 16'h0000, "abort_rd2");
    abort_write(1, 16'h0020, 16'h1234);
    do_access(1, 1'b1, 16'h0020, 16'h0000, "abort_rd1");
  endtask

  task automatic protocol_err(input int s);
    logic [15:0] p, o0, o1;
    @(posedge clk); #1;
    rd_r[s] = 1'b1; wr_r[s] = 1'b1; addr_r[s] = 16'h0010;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 3) rd_r[s] = 1'b0;
      p = 16'($urandom);
      sense(s, p, o0);
      sense(s, ~p, o1);
      n_cmp++;
      if (err_of(s) !== 1'b1 || rdy_of(s) !== 1'b0 || o0 !== p || o1 !== ~p) begin
        n_bad++;
        $display("FAIL err dut%0d cycle %0d: err %b ready %b bus %h/%h required 1 0 %h/%h",
                 s, c, err_of(s), rdy_of(s), o0, o1, p, ~p);
      end
    end
    wr_r[s] = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (err_of(s) !== 1'b0) begin
      n_bad++;
      $display("FAIL err dut%0d exit: err %b required 0", s, err_of(s));
    end
  endtask

  task automatic test_protocol_err();
    protocol_err(0);
    do_access(0, 1'b1, 16'h0010, 16'h0000, "err_rd");
  endtask

  task automatic test_alias();
    do_access(1, 1'b0, 16'h0105, 16'h00AA, "alias_wr1");
    do_access(1, 1'b1, 16'h0005, 16'h0000, "alias_rd1");
    do_access(0, 1'b0, 16'hFF07, 16'h0C0D, "alias_wr2");
    do_access(0, 1'b1, 16'h0007, 16'h0000, "alias_rd2");
  endtask

  task automatic test_reset_mid();
    logic [15:0] p, o0, o1;
    do_access(0, 1'b0, 16'h0031, 16'hA5C3, "persist_wr");
    // reset while a read is returning data
    @(posedge clk); #1;
    addr_r[0] = 16'h0010; rd_r[0] = 1'b1;
    repeat (lat[0] + 1) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus_of(0) !== mem_m[0][16]) begin
      n_bad++;
      $display("FAIL reset_done pre read: saw %h required %h", bus_of(0), mem_m[0][16]);
    end
    #1; reset_n = 1'b0;
    p = 16'($urandom);
    sense(0, p, o0);
    sense(0, ~p, o1);
    n_cmp++;
    if (o0 !== p || o1 !== ~p || rdy_of(0) !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_done release: bus %h/%h ready %b required %h/%h 0", o0, o1, rdy_of(0), p, ~p);
    end
    rd_r[0] = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    // reset while a write is still in BUSY
    @(posedge clk); #1;
    addr_r[0] = 16'h0030; wr_r[0] = 1'b1; tb_en[0] = 1'b1; tb_dat[0] = 16'h5555;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (rdy_of(0) !== 1'b0 || err_of(0) !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_busy outputs: ready %b err %b required 0 0", rdy_of(0), err_of(0));
    end
    wr_r[0] = 1'b0; tb_en[0] = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    do_access(0, 1'b1, 16'h0030, 16'h0000, "reset_busy_rd");
    do_access(0, 1'b1, 16'h0031, 16'h0000, "persist_rd");
  endtask

  task automatic test_random();
    int          s;
    bit          is_rd;
    logic [15:0] a, d;
    for (int i = 0; i < 30; i++) begin
      s     = int'($urandom_range(0, 1));
      is_rd = 1'($urandom_range(0, 1));
      a     = {8'($urandom), 8'($urandom_range(64, 71))};
      d     = 16'($urandom);
      do_access(s, is_rd, a, d, "random");
    end
  endtask

`ifdef MEM_ACCESS_CNT_EN
  task automatic test_counts();
    @(negedge clk); reset_n = 1'b0;
    #1;
    n_cmp++;
    if (rc0 !== 16'd0 || wc0 !== 16'd0) begin
      n_bad++;
      $display("FAIL count reset: rd %0d wr %0d required 0 0", rc0, wc0);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 3; i++) do_access(0, 1'b0, 16'(16'h0050 + i), 16'($urandom), "cnt_wr");
    for (int i = 0; i < 2; i++) do_access(0, 1'b1, 16'(16'h0050 + i), 16'h0000, "cnt_rd");
    abort_write(0, 16'h0058, 16'h7777);
    protocol_err(0);
    @(negedge clk);
    n_cmp++;
    if (wc0 !== 16'd3 || rc0 !== 16'd2 || wc1 !== 16'd0 || rc1 !== 16'd0) begin
      n_bad++;
      $display("FAIL counts: dut2 wr %0d rd %0d dut1 wr %0d rd %0d required 3 2 0 0", wc0, rc0, wc1, rc1);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rd_r[s] = 1'b0; wr_r[s] = 1'b0; addr_r[s] = 16'h0000;
      tb_en[s] = 1'b0; tb_dat[s] = 16'h0000;
      for (int w = 0; w < 256; w++) mem_m[s][w] = 16'h0000;
    end
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    @(negedge clk); reset_n = 1'b1;
    test_basic();
    test_abort();
    test_protocol_err();
    test_alias();
    test_reset_mid();
    test_random();
`ifdef MEM_ACCESS_CNT_EN
    test_counts();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
